ps2_key_decoder: RTL and testbench

Upstream input stage of the Flappy Bird keyboard path. It receives raw PS/2 clock and data from the keyboard connector and frames 11-bit PS/2 packets. It decodes make/break/extended prefixes and produces a single-cycle spacebar_pressed pulse for the game logic, plus the last scan code for the board LEDs. It runs on the 50 MHz board clock.

---
 rtl/ps2_key_decoder.sv | 273 +++++++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// -----------------------------------------------------------------------------
// ps2_key_decoder
//
// Keyboard input stage for the Flappy Bird game. This block synchronizes and
// de-glitches the raw PS/2 clock and frames 11-bit PS/2 packets. It decodes the
// make, break (F0) and extended (E0) prefixes. It turns the spacebar into a
// one-shot "pressed" pulse and a "held" level.
//
// Optional feature (compile-time macro): PS2_PARITY_CHECK_EN
//   defined   : odd parity over D0..D7 + parity bit is checked; failing
//               frames are dropped and parity_err pulses.
//   undefined : the parity bit is ignored and parity_err is tied to 0.
//
// Parameters
//   FILTER_LEN      consecutive identical ps2c samples needed to accept a
//                   new ps2c level
//   TIMEOUT_CYCLES  clk cycles without a ps2c falling edge mid-frame before
//                   the frame is aborted
//   SPACE_CODE      make code of the spacebar
//
// Ports
//   clk              board clock (50 MHz)
//   rst              asynchronous, active-high reset
//   ps2c, ps2d       raw PS/2 clock / data, asynchronous to clk
//   scan_code        last accepted byte (prefix bytes included)
//   led              mirror of scan_code
//   code_valid       1-cycle pulse when scan_code takes a new byte
//   spacebar_pressed 1-cycle pulse on a fresh (non-repeat) spacebar make
//   space_down       level, spacebar currently held
//   frame_err        1-cycle pulse on bad stop bit or mid-frame timeout
//   parity_err       1-cycle pulse on odd-parity failure
//
// scan_code, led, code_valid, spacebar_pressed, frame_err and parity_err are
// decoded combinationally from the CHECK/RECV state registers. They are
// therefore visible in the CHECK cycle itself. space_down is registered and
// follows one cycle later.
// -----------------------------------------------------------------------------
module ps2_key_decoder #(
    parameter int         FILTER_LEN     = 8,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] SPACE_CODE     = 8'h29
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] scan_code,
    output logic [7:0] led,
    output logic       code_valid,
    output logic       spacebar_pressed,
    output logic       space_down,
    output logic       frame_err,
    output logic       parity_err
);

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int         FCW        = $clog2(FILTER_LEN + 1);
    localparam int         TCW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // 2-FF synchronizers. Bit 0 carries ps2c and bit 1 carries ps2d. Both
    // idle high, so they reset to 1 and a reset produces no false edge.
    // ------------------------------------------------------------------
    logic [1:0] raw_in;
    logic [1:0] sync_bits;

    assign raw_in = {ps2d, ps2c};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= raw_in[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_bits[gi] = sync_reg;
        end
    endgenerate

    logic ps2c_sync;
    logic ps2d_sync;

    assign ps2c_sync = sync_bits[0];
    assign ps2d_sync = sync_bits[1];

    // ------------------------------------------------------------------
    // Glitch filter on ps2c. The filtered level flips only after
    // FILTER_LEN consecutive samples disagree with it. Any agreeing sample
    // restarts the count.
    // ------------------------------------------------------------------
    logic           filt_reg, filt_next;
    logic           filt_d_reg;
    logic [FCW-1:0] filt_cnt_reg, filt_cnt_next;
    logic           fall_edge;

    always_comb begin
        filt_next     = filt_reg;
        filt_cnt_next = '0;
        if (ps2c_sync != filt_reg) begin
            if (filt_cnt_reg == FCW'(FILTER_LEN - 1)) begin
                filt_next = ps2c_sync;
            end else begin
                filt_cnt_next = filt_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_reg     <= 1'b1;
            filt_d_reg   <= 1'b1;
            filt_cnt_reg <= '0;
        end else begin
            filt_reg     <= filt_next;
            filt_d_reg   <= filt_reg;
            filt_cnt_reg <= filt_cnt_next;
        end
    end

    assign fall_edge = filt_d_reg & ~filt_reg;

    // ------------------------------------------------------------------
    // Frame FSM and decode state
    // ------------------------------------------------------------------
    state_t         state_reg, state_next;
    logic [3:0]     bit_cnt_reg, bit_cnt_next;
    logic [10:0]    shift_reg, shift_next;
    logic [TCW-1:0] tmo_reg, tmo_next;
    logic [7:0]     scan_code_reg, scan_code_next;
    logic           break_pending_reg, break_pending_next;
    logic           ext_pending_reg, ext_pending_next;
    logic           space_down_reg, space_down_next;

    // Bits shift in from the top. After 11 edges, bit 0 holds the start bit,
    // [8:1] hold D0..D7, [9] holds parity and [10] holds stop.
    logic [7:0] rx_byte;
    logic       stop_ok;
    logic       parity_ok;

    assign rx_byte   = shift_reg[8:1];
    assign stop_ok   = shift_reg[10];
    assign parity_ok = ^shift_reg[9:1];

    always_comb begin
        state_next         = state_reg;
        bit_cnt_next       = bit_cnt_reg;
        shift_next         = shift_reg;
        tmo_next           = tmo_reg;
        scan_code_next     = scan_code_reg;
        break_pending_next = break_pending_reg;
        ext_pending_next   = ext_pending_reg;
        space_down_next    = space_down_reg;
        code_valid         = 1'b0;
        spacebar_pressed   = 1'b0;
        frame_err          = 1'b0;
        parity_err         = 1'b0;

        case (state_reg)
            IDLE: begin
                tmo_next = '0;
                // A start bit of 1 is noise and is ignored.
                if (fall_edge && !ps2d_sync) begin
                    shift_next   = {ps2d_sync, shift_reg[10:1]};
                    bit_cnt_next = 4'd1;
                    state_next   = RECV;
                end
            end

            RECV: begin
                if (tmo_reg == TCW'(TIMEOUT_CYCLES)) begin
                    // The counter saturated. Abort and discard the partial byte.
                    frame_err    = 1'b1;
                    shift_next   = '0;
                    bit_cnt_next = '0;
                    state_next   = IDLE;
                end else if (fall_edge) begin
                    shift_next = {ps2d_sync, shift_reg[10:1]};
                    tmo_next   = '0;
                    if (bit_cnt_reg == 4'd10) begin
                        bit_cnt_next = '0;
                        state_next   = CHECK;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end

            CHECK: begin
                state_next = IDLE;
                if (!stop_ok) begin
                    frame_err = 1'b1;
                end else if (PARITY_EN && !parity_ok) begin
                    parity_err = 1'b1;
                end else begin
                    code_valid     = 1'b1;
                    scan_code_next = rx_byte;
                    if (rx_byte == BREAK_CODE) begin
                        break_pending_next = 1'b1;
                    end else if (rx_byte == EXT_CODE) begin
                        ext_pending_next = 1'b1;
                    end else begin
                        // An extended E0 29 shares the code but is a different key.
                        if (rx_byte == SPACE_CODE && !ext_pending_reg) begin
                            if (break_pending_reg) begin
                                space_down_next = 1'b0;
                            end else if (!space_down_reg) begin
                                space_down_next  = 1'b1;
                                spacebar_pressed = 1'b1;
                            end
                        end
                        break_pending_next = 1'b0;
                        ext_pending_next   = 1'b0;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            bit_cnt_reg       <= '0;
            shift_reg         <= '0;
            tmo_reg           <= '0;
            scan_code_reg     <= '0;
            break_pending_reg <= 1'b0;
            ext_pending_reg   <= 1'b0;
            space_down_reg    <= 1'b0;
        end else begin
            state_reg         <= state_next;
            bit_cnt_reg       <= bit_cnt_next;
            shift_reg         <= shift_next;
            tmo_reg           <= tmo_next;
            scan_code_reg     <= scan_code_next;
            break_pending_reg <= break_pending_next;
            ext_pending_reg   <= ext_pending_next;
            space_down_reg    <= space_down_next;
        end
    end

    // scan_code shows the new byte during the CHECK cycle itself.
    assign scan_code  = scan_code_next;
    assign led        = scan_code_next;
    assign space_down = space_down_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// -----------------------------------------------------------------------------
// tb_ps2_key_decoder
//
// Directed bench for ps2_key_decoder. It shortens the timeout and the PS/2 bit
// period to keep the run short. The bit period is 200 clk and the timeout is
// 1000 clk. Pulse outputs are counted by a negedge monitor. Each step compares
// the count deltas and the resting output levels with hand-derived constants.
// -----------------------------------------------------------------------------
module tb_ps2_key_decoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1000;
    localparam int HALF       = 100;
    // Raw ps2c fall -> edge acted on: 2 sync stages + FILTER_LEN filter
    // samples + 1 edge register.
    localparam int EDGE_LAT   = FILTER_LEN + 3;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic [7:0] scan_code;
    logic [7:0] led;
    logic       code_valid;
    logic       spacebar_pressed;
    logic       space_down;
    logic       frame_err;
    logic       parity_err;

    ps2_key_decoder #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT),
        .SPACE_CODE    (8'h29)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ps2c            (ps2c),
        .ps2d            (ps2d),
        .scan_code       (scan_code),
        .led             (led),
        .code_valid      (code_valid),
        .spacebar_pressed(spacebar_pressed),
        .space_down      (space_down),
        .frame_err       (frame_err),
        .parity_err      (parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor
    int cv_cnt = 0, sp_cnt = 0, fe_cnt = 0, pe_cnt = 0;
    int orphan_sp = 0, led_diff = 0, fe_cyc = 0;
    always @(negedge clk) begin
        if (code_valid)                      cv_cnt    <= cv_cnt + 1;
        if (spacebar_pressed)                sp_cnt    <= sp_cnt + 1;
        if (spacebar_pressed && !code_valid) orphan_sp <= orphan_sp + 1;
        if (parity_err)                      pe_cnt    <= pe_cnt + 1;
        if (led !== scan_code)               led_diff  <= led_diff + 1;
        if (frame_err) begin
            fe_cnt <= fe_cnt + 1;
            fe_cyc <= cyc;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cv0, sp0, fe0, pe0;
    int last_fall_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        cv0 = cv_cnt;
        sp0 = sp_cnt;
        fe0 = fe_cnt;
        pe0 = pe_cnt;
    endtask

    // Send one frame, or the first nbits of one. When glitch is set, 3-cycle
    // spikes are added to ps2c in a high phase (bit 4) and in a low phase
    // (bit 6).
    task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                              input int nbits, input bit glitch);
        logic [10:0] bits;
        bits[0]   = 1'b0;
        bits[8:1] = data;
        bits[9]   = (~^data) ^ bad_par;
        bits[10]  = ~bad_stop;
        for (int i = 0; i < nbits; i++) begin
            ps2d = bits[i];
            if (glitch && i == 4) begin
                repeat (HALF / 2) @(negedge clk);
                ps2c = 1'b0;
                repeat (3) @(negedge clk);
                ps2c = 1'b1;
                repeat (HALF / 2 - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2c = 1'b0;
            last_fall_cyc = cyc;
            if (glitch && i == 6) begin
                repeat (HALF / 2) @(negedge clk);
                ps2c = 1'b1;
                repeat (3) @(negedge clk);
                ps2c = 1'b0;
                repeat (HALF / 2 - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        $display("frame %02h bits=%0d par_flip=%0b stop_bad=%0b glitch=%0b done at cyc %0d",
                 data, nbits, bad_par, bad_stop, glitch, cyc);
    endtask

    task automatic send(input logic [7:0] data);
        send_frame(data, 1'b0, 1'b0, 11, 1'b0);
    endtask

    task automatic idle_glitch();
        ps2c = 1'b0;
        repeat (3) @(negedge clk);
        ps2c = 1'b1;
        repeat (50) @(negedge clk);
    endtask

    initial begin
        int guard;

        // Reset state
        repeat (5) @(negedge clk);
        check_eq("rst_scan_code", scan_code, 0);
        check_eq("rst_led", led, 0);
        check_eq("rst_pulses", {code_valid, spacebar_pressed, frame_err, parity_err}, 0);
        check_eq("rst_space_down", space_down, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Clean spacebar make
        snap();
        send(8'h29);
        check_eq("a_code_valid", cv_cnt - cv0, 1);
        check_eq("a_space_pulse", sp_cnt - sp0, 1);
        check_eq("a_pulse_same_cycle", orphan_sp, 0);
        check_eq("a_scan_code", scan_code, 8'h29);
        check_eq("a_led", led, 8'h29);
        check_eq("a_space_down", space_down, 1);

        // Typematic repeats, then break
        snap();
        send(8'h29);
        send(8'h29);
        check_eq("b_repeat_down", space_down, 1);
        send(8'hF0);
        check_eq("b_break_scan", scan_code, 8'hF0);
        check_eq("b_break_prefix_down", space_down, 1);
        send(8'h29);
        check_eq("b_code_valid", cv_cnt - cv0, 4);
        check_eq("b_space_pulse", sp_cnt - sp0, 0);
        check_eq("b_space_up", space_down, 0);
        check_eq("b_scan_code", scan_code, 8'h29);

        // Extended E0 29 must not touch the spacebar
        snap();
        send(8'h29);
        send(8'hE0);
        check_eq("c_ext_scan", scan_code, 8'hE0);
        send(8'h29);
        check_eq("c_ext_make_down", space_down, 1);
        check_eq("c_ext_scan2", scan_code, 8'h29);
        send(8'hE0);
        send(8'hF0);
        send(8'h29);
        check_eq("c_ext_break_down", space_down, 1);
        send(8'hF0);
        send(8'h29);
        check_eq("c_space_pulse", sp_cnt - sp0, 1);
        check_eq("c_code_valid", cv_cnt - cv0, 8);
        check_eq("c_space_up", space_down, 0);

        // Parity bit flipped on 0x1C
        snap();
        send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        check_eq("d_parity_err", pe_cnt - pe0, 1);
        check_eq("d_code_valid", cv_cnt - cv0, 0);
        check_eq("d_scan_code", scan_code, 8'h29);
`else
        check_eq("d_parity_err", pe_cnt - pe0, 0);
        check_eq("d_code_valid", cv_cnt - cv0, 1);
        check_eq("d_scan_code", scan_code, 8'h1C);
`endif

        // Bad stop bit on a spacebar frame
        snap();
        send_frame(8'h29, 1'b0, 1'b1, 11, 1'b0);
        check_eq("e_frame_err", fe_cnt - fe0, 1);
        check_eq("e_code_valid", cv_cnt - cv0, 0);
        check_eq("e_space_down", space_down, 0);

        // Truncated frame: 5 edges, then silence
        snap();
        send_frame(8'h29, 1'b0, 1'b0, 5, 1'b0);
        guard = 0;
        while (fe_cnt == fe0 && guard < TIMEOUT + 500) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check_eq("f_frame_err", fe_cnt - fe0, 1);
        check_eq("f_timeout_delay", fe_cyc - last_fall_cyc, TIMEOUT + EDGE_LAT);
        check_eq("f_code_valid", cv_cnt - cv0, 0);
        snap();
        send(8'h29);
        check_eq("f_next_code_valid", cv_cnt - cv0, 1);
        check_eq("f_next_space_pulse", sp_cnt - sp0, 1);
        check_eq("f_next_scan", scan_code, 8'h29);

        // Glitches on ps2c in IDLE and in RECV
        snap();
        idle_glitch();
        idle_glitch();
        idle_glitch();
        send_frame(8'h5A, 1'b0, 1'b0, 11, 1'b1);
        check_eq("g_code_valid", cv_cnt - cv0, 1);
        check_eq("g_errors", (fe_cnt - fe0) + (pe_cnt - pe0), 0);
        check_eq("g_scan_code", scan_code, 8'h5A);
        check_eq("g_space_down", space_down, 1);

        // Break prefix pending, then reset in the middle of a frame
        send(8'hF0);
        send_frame(8'h29, 1'b0, 1'b0, 6, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("h_rst_scan", scan_code, 0);
        check_eq("h_rst_led", led, 0);
        check_eq("h_rst_space_down", space_down, 0);
        check_eq("h_rst_pulses", {code_valid, spacebar_pressed, frame_err, parity_err}, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        snap();
        send(8'h29);
        check_eq("h_after_code_valid", cv_cnt - cv0, 1);
        check_eq("h_after_space_pulse", sp_cnt - sp0, 1);
        check_eq("h_after_space_down", space_down, 1);
        check_eq("h_after_frame_err", fe_cnt - fe0, 0);

        check_eq("led_mirror", led_diff, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
